vga_segment_timing_counter: RTL and testbench

Parametrised, chainable single-axis VGA timing counter. It generalises the enabled frame counter with zero/threshold detect into a full segment sequencer:
- programmable visible / front-porch / sync / back-porch boundaries;
- polarity-selectable sync output;
- region state machine;
- terminal-count carry, so one horizontal instance can drive the enable of a vertical instance.

It sits between the pixel-clock domain and the pixel/sync output stage of the VGA controller.

---
 rtl/vga_segment_timing_counter.sv | 103 ++++++++++
 tb/tb_vga_segment_timing_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_segment_timing_counter.sv
// Single-axis VGA timing counter: count, region FSM, registered sync and detect decodes.
// terminal_count is combinational so that a second instance can chain off it.
module vga_segment_timing_counter #(
    parameter int COUNTER_SIZE    = 11,
    parameter int TOTAL           = 1328,
    parameter int VISIBLE_END     = 1024,
    parameter int SYNC_START      = 1048,
    parameter int SYNC_END        = 1184,
    parameter int THRESHOLD       = 1072,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    counter_enable,
    output logic [COUNTER_SIZE-1:0] counter_output,
    output logic [1:0]              region,
    output logic                    visible,
    output logic                    sync_out,
    output logic                    zero_detected,
    output logic                    threshold_detected,
    output logic                    terminal_count
);

    if (!(VISIBLE_END > 0 && VISIBLE_END <= SYNC_START && SYNC_START < SYNC_END &&
          SYNC_END <= TOTAL && THRESHOLD >= 0 && THRESHOLD < TOTAL &&
          TOTAL <= (1 << COUNTER_SIZE))) begin : g_param_check
        $error("vga_segment_timing_counter: illegal segment boundary parameters");
    end

    typedef enum logic [1:0] {
        REG_VISIBLE = 2'd0,
        REG_FRONT   = 2'd1,
        REG_SYNC    = 2'd2,
        REG_BACK    = 2'd3
    } region_t;

    localparam int                    LAST         = TOTAL - 1;
    localparam logic [COUNTER_SIZE-1:0] C_LAST     = LAST[COUNTER_SIZE-1:0];
    localparam logic [COUNTER_SIZE-1:0] C_THRESH   = THRESHOLD[COUNTER_SIZE-1:0];
    // Boundaries carry one extra bit because SYNC_END may equal 2^COUNTER_SIZE.
    localparam logic [COUNTER_SIZE:0]   C_VIS_END  = VISIBLE_END[COUNTER_SIZE:0];
    localparam logic [COUNTER_SIZE:0]   C_SYNC_BEG = SYNC_START[COUNTER_SIZE:0];
    localparam logic [COUNTER_SIZE:0]   C_SYNC_END = SYNC_END[COUNTER_SIZE:0];
    localparam logic                    C_SYNC_ON  = !SYNC_ACTIVE_LOW;

    logic [COUNTER_SIZE-1:0] r_count;
    logic [COUNTER_SIZE-1:0] w_count_next;
    logic [COUNTER_SIZE:0]   w_next_ext;
    logic                    w_last;
    region_t                 r_region;
    region_t                 w_region_next;
    logic                    r_sync;

    always_comb begin
        w_last       = (r_count == C_LAST);
        w_count_next = w_last ? '0 : r_count + 1'b1;
        w_next_ext   = {1'b0, w_count_next};
    end

    // Transitions look at the next count so region changes on the same edge as the count.
    always_comb begin
        w_region_next = r_region;
        case (r_region)
            REG_VISIBLE: begin
                if (w_last)                          w_region_next = REG_VISIBLE;
                else if (w_next_ext == C_SYNC_BEG)   w_region_next = REG_SYNC;
                else if (w_next_ext == C_VIS_END)    w_region_next = REG_FRONT;
            end
            REG_FRONT: begin
                if (w_next_ext == C_SYNC_BEG)        w_region_next = REG_SYNC;
            end
            REG_SYNC: begin
                if (w_last)                          w_region_next = REG_VISIBLE;
                else if (w_next_ext == C_SYNC_END)   w_region_next = REG_BACK;
            end
            REG_BACK: begin
                if (w_last)                          w_region_next = REG_VISIBLE;
            end
            default:                                 w_region_next = REG_VISIBLE;
        endcase
    end

    always_ff @(posedge control_clock) begin
        if (!control_reset_n) begin
            r_count  <= '0;
            r_region <= REG_VISIBLE;
            r_sync   <= !C_SYNC_ON;
        end else if (counter_enable) begin
            r_count  <= w_count_next;
            r_region <= w_region_next;
            r_sync   <= (w_region_next == REG_SYNC) ? C_SYNC_ON : !C_SYNC_ON;
        end
    end

    assign counter_output     = r_count;
    assign region             = r_region;
    assign visible            = (r_region == REG_VISIBLE);
    assign sync_out           = r_sync;
    assign zero_detected      = (r_count == '0);
    assign threshold_detected = (r_count == C_THRESH);
    assign terminal_count     = counter_enable && w_last;

endmodule

// File: tb/tb_vga_segment_timing_counter.sv
// Directed bench for vga_segment_timing_counter: default line, chained H/V pair, edge parameters.
module tb_vga_segment_timing_counter;

    logic clk;
    int   n_vec;
    int   n_err;

    // Default instance
    logic        d_rst_n, d_en;
    logic [10:0] d_cnt;
    logic [1:0]  d_reg;
    logic        d_vis, d_sync, d_zero, d_thr, d_tc;

    // Chained pair
    logic        ch_rst_n, h_en;
    logic [2:0]  h_cnt;
    logic [1:0]  h_reg;
    logic        h_vis, h_sync, h_zero, h_thr, h_tc;
    logic [9:0]  v_cnt;
    logic [1:0]  v_reg;
    logic        v_vis, v_sync, v_zero, v_thr, v_tc;

    // Zero-length FRONT/BACK instance, active-high sync
    logic        e_rst_n, e_en;
    logic [2:0]  e_cnt;
    logic [1:0]  e_reg;
    logic        e_vis, e_sync, e_zero, e_thr, e_tc;

    vga_segment_timing_counter u_d (
        .control_clock(clk), .control_reset_n(d_rst_n), .counter_enable(d_en),
        .counter_output(d_cnt), .region(d_reg), .visible(d_vis), .sync_out(d_sync),
        .zero_detected(d_zero), .threshold_detected(d_thr), .terminal_count(d_tc));

    vga_segment_timing_counter #(
        .COUNTER_SIZE(3), .TOTAL(8), .VISIBLE_END(5), .SYNC_START(6), .SYNC_END(7),
        .THRESHOLD(3), .SYNC_ACTIVE_LOW(1'b1)
    ) u_h (
        .control_clock(clk), .control_reset_n(ch_rst_n), .counter_enable(h_en),
        .counter_output(h_cnt), .region(h_reg), .visible(h_vis), .sync_out(h_sync),
        .zero_detected(h_zero), .threshold_detected(h_thr), .terminal_count(h_tc));

    vga_segment_timing_counter #(
        .COUNTER_SIZE(10), .TOTAL(806), .VISIBLE_END(768), .SYNC_START(771), .SYNC_END(777),
        .THRESHOLD(800), .SYNC_ACTIVE_LOW(1'b1)
    ) u_v (
        .control_clock(clk), .control_reset_n(ch_rst_n), .counter_enable(h_tc),
        .counter_output(v_cnt), .region(v_reg), .visible(v_vis), .sync_out(v_sync),
        .zero_detected(v_zero), .threshold_detected(v_thr), .terminal_count(v_tc));

    vga_segment_timing_counter #(
        .COUNTER_SIZE(3), .TOTAL(8), .VISIBLE_END(4), .SYNC_START(4), .SYNC_END(8),
        .THRESHOLD(2), .SYNC_ACTIVE_LOW(1'b0)
    ) u_e (
        .control_clock(clk), .control_reset_n(e_rst_n), .counter_enable(e_en),
        .counter_output(e_cnt), .region(e_reg), .visible(e_vis), .sync_out(e_sync),
        .zero_detected(e_zero), .threshold_detected(e_thr), .terminal_count(e_tc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int rst_n;
        int en;
        int tc;
        int cnt;
        int rg;
        int sync;
    } vec_t;

    vec_t tbl [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int d_region(input int k);
        if (k < 1024) return 0;
        if (k < 1048) return 1;
        if (k < 1184) return 2;
        return 3;
    endfunction

    task automatic chk_d(input string tag, input int k);
        chk({tag, "_cnt"},    d_cnt, k);
        chk({tag, "_region"}, d_reg, d_region(k));
        chk({tag, "_visible"}, d_vis, (k < 1024));
        chk({tag, "_sync"},   d_sync, (k >= 1048 && k < 1184) ? 0 : 1);
        chk({tag, "_zero"},   d_zero, (k == 0));
        chk({tag, "_thr"},    d_thr, (k == 1072));
    endtask

    initial begin
        int exp_k;
        int tc_pulses;
        int thr_cycles;
        int hk;
        int vk;

        n_vec = 0;
        n_err = 0;
        d_rst_n = 1'b0; d_en = 1'b0;
        ch_rst_n = 1'b0; h_en = 1'b0;
        e_rst_n = 1'b0; e_en = 1'b0;

        tbl = '{
            '{0,0,0, 0,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 2,0,0}, '{1,1,0, 3,0,0},
            '{1,1,0, 4,2,1}, '{1,1,0, 5,2,1}, '{1,1,0, 6,2,1}, '{1,1,0, 7,2,1},
            '{1,1,1, 0,0,0}, '{1,0,0, 0,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 2,0,0},
            '{1,1,0, 3,0,0}, '{1,1,0, 4,2,1}, '{1,1,0, 5,2,1}, '{0,1,0, 0,0,0},
            '{1,0,0, 0,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 2,0,0}, '{1,1,0, 3,0,0},
            '{1,1,0, 4,2,1}, '{1,1,0, 5,2,1}, '{1,1,0, 6,2,1}, '{1,1,0, 7,2,1},
            '{1,0,0, 7,2,1}, '{1,0,0, 7,2,1}, '{1,1,1, 0,0,0}
        };

        // Reset state and two full lines with enable held high
        tick();
        chk_d("rst", 0);
        chk("rst_tc", d_tc, 0);
        d_rst_n = 1'b1;
        d_en = 1'b1;
        #1;
        tc_pulses = 0;
        for (int i = 0; i < 2 * 1328; i++) begin
            chk_d("line", i % 1328);
            chk("line_tc", d_tc, ((i % 1328) == 1327));
            if (d_tc) tc_pulses++;
            tick();
        end
        chk("line_tc_pulses", tc_pulses, 2);
        chk_d("line_wrapped", 0);

        // Enable toggled across the FRONT->SYNC boundary and the threshold
        for (int i = 0; i < 1047; i++) tick();
        chk_d("tog_start", 1047);
        exp_k = 1047;
        thr_cycles = 0;
        for (int j = 0; j < 56; j++) begin
            d_en = (j % 2 == 0);
            tick();
            if (j % 2 == 0) exp_k++;
            chk_d("tog", exp_k);
            if (d_thr) thr_cycles++;
        end
        chk("tog_thr_cycles", thr_cycles, 2);

        // Reset mid-line while in SYNC, with enable high
        d_en = 1'b1;
        while (exp_k < 1100) begin
            tick();
            exp_k++;
        end
        chk_d("mid_pre", 1100);
        d_rst_n = 1'b0;
        tick();
        chk_d("mid_rst", 0);
        d_rst_n = 1'b1;
        d_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_d("mid_hold", 0);
        end
        d_en = 1'b1;
        tick();
        chk_d("mid_resume", 1);

        // Enable held low at TOTAL-1
        exp_k = 1;
        while (exp_k < 1327) begin
            tick();
            exp_k++;
        end
        chk_d("last_pre", 1327);
        d_en = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("last_hold_tc", d_tc, 0);
            tick();
            chk_d("last_hold", 1327);
        end
        d_en = 1'b1;
        #1;
        chk("last_en_tc", d_tc, 1);
        tick();
        chk_d("last_wrap", 0);
        chk("last_wrap_tc", d_tc, 0);

        // Chained horizontal/vertical pair
        tick();
        chk("ch_rst_h", h_cnt, 0);
        chk("ch_rst_v", v_cnt, 0);
        chk("ch_rst_vsync", v_sync, 1);
        ch_rst_n = 1'b1;
        h_en = 1'b1;
        #1;
        tc_pulses = 0;
        for (int i = 0; i < 806 * 8 + 16; i++) begin
            hk = i % 8;
            vk = (i / 8) % 806;
            chk("ch_h_cnt", h_cnt, hk);
            chk("ch_v_cnt", v_cnt, vk);
            chk("ch_v_sync", v_sync, (vk >= 771 && vk <= 776) ? 0 : 1);
            chk("ch_h_tc", h_tc, (hk == 7));
            chk("ch_v_tc", v_tc, (hk == 7 && vk == 805));
            if (v_tc) tc_pulses++;
            tick();
        end
        chk("ch_v_tc_pulses", tc_pulses, 1);

        // Zero-length FRONT and BACK, active-high sync
        for (int r = 0; r < 27; r++) begin
            e_rst_n = (tbl[r].rst_n != 0);
            e_en    = (tbl[r].en != 0);
            #1;
            chk("edge_tc", e_tc, tbl[r].tc);
            tick();
            chk("edge_cnt", e_cnt, tbl[r].cnt);
            chk("edge_region", e_reg, tbl[r].rg);
            chk("edge_sync", e_sync, tbl[r].sync);
            chk("edge_visible", e_vis, (tbl[r].rg == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
